// File: rtl/ingress_arbiter_if.sv
// Stream interfaces for the ingress arbiter: plain per-source ingress streams
// and the VNP4-tagged merged stream that carries source/destination metadata.
interface axi_stream_if #(
  parameter int DATA_W = 64,
  parameter int SIZE_W = 16
);
  logic                valid;
  logic                ready;
  logic [DATA_W-1:0]   data;
  logic [DATA_W/8-1:0] keep;
  logic                last;
  logic [SIZE_W-1:0]   user_size;

  modport master (output valid, data, keep, last, user_size, input ready);
  modport slave  (input valid, data, keep, last, user_size, output ready);
endinterface

interface axi_stream_vnp4_if #(
  parameter int DATA_W   = 64,
  parameter int SIZE_W   = 16,
  parameter int NUM_PF   = 1,
  parameter int NUM_CMAC = 1
);
  logic                valid;
  logic                ready;
  logic [DATA_W-1:0]   data;
  logic [DATA_W/8-1:0] keep;
  logic                last;
  logic [SIZE_W-1:0]   user_size;
  logic [NUM_PF-1:0]   user_src_pf;
  logic [NUM_PF-1:0]   user_dst_pf;
  logic [NUM_CMAC-1:0] user_src_cmac;
  logic [NUM_CMAC-1:0] user_dst_cmac;
  logic                user_to_direction;
  logic                user_valid;

  modport master (output valid, data, keep, last, user_size, user_src_pf, user_dst_pf,
                  user_src_cmac, user_dst_cmac, user_to_direction, user_valid,
                  input ready);
  modport slave  (input valid, data, keep, last, user_size, user_src_pf, user_dst_pf,
                  user_src_cmac, user_dst_cmac, user_to_direction, user_valid,
                  output ready);
endinterface

// File: rtl/ingress_arbiter.sv
// Packet-level round-robin merge of PF and CMAC ingress streams into one registered VNP4 stream.
// Optional packet counter port pkt_count is built when INGRESS_ARBITER_STATS_EN is defined.
module ingress_arbiter #(
  parameter int NUM_PHYS_FUNC = 1,
  parameter int NUM_CMAC_PORT = 1,
  parameter int DATA_W        = 64,
  parameter int SIZE_W        = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  axi_stream_if.slave        s_axis_pf   [NUM_PHYS_FUNC],
  axi_stream_if.slave        s_axis_cmac [NUM_CMAC_PORT],
  axi_stream_vnp4_if.master  m_axis
`ifdef INGRESS_ARBITER_STATS_EN
  , output logic [31:0]      pkt_count
`endif
);

  localparam int NUM_REQ = NUM_PHYS_FUNC + NUM_CMAC_PORT;
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int KEEP_W  = DATA_W / 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d, rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]   winner, selIdx;
  logic               found, selActive, canTake, accept;

  logic [NUM_REQ-1:0] reqValid, reqReady, reqLast, selOneHot;
  logic [DATA_W-1:0]  reqData [NUM_REQ];
  logic [KEEP_W-1:0]  reqKeep [NUM_REQ];
  logic [SIZE_W-1:0]  reqSize [NUM_REQ];

  logic               bufValid_q, bufLast_q;
  logic [DATA_W-1:0]  bufData_q;
  logic [KEEP_W-1:0]  bufKeep_q;
  logic [SIZE_W-1:0]  bufSize_q;
  logic [NUM_REQ-1:0] bufSrc_q;

  // Flatten both source groups into one requestor vector: PFs first, then CMACs.
  for (genvar g = 0; g < NUM_PHYS_FUNC; g++) begin : gPf
    assign reqValid[g]       = s_axis_pf[g].valid;
    assign reqData[g]        = s_axis_pf[g].data;
    assign reqKeep[g]        = s_axis_pf[g].keep;
    assign reqLast[g]        = s_axis_pf[g].last;
    assign reqSize[g]        = s_axis_pf[g].user_size;
    assign s_axis_pf[g].ready = reqReady[g];
  end

  for (genvar g = 0; g < NUM_CMAC_PORT; g++) begin : gCmac
    localparam int R = NUM_PHYS_FUNC + g;
    assign reqValid[R]          = s_axis_cmac[g].valid;
    assign reqData[R]           = s_axis_cmac[g].data;
    assign reqKeep[R]           = s_axis_cmac[g].keep;
    assign reqLast[R]           = s_axis_cmac[g].last;
    assign reqSize[R]           = s_axis_cmac[g].user_size;
    assign s_axis_cmac[g].ready = reqReady[R];
  end

  // Wrap-around search for the first valid requestor starting at rrPtr_q.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && reqValid[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rrPtr_d   = rrPtr_q;
    reqReady  = '0;
    selIdx    = (state_q == LOCKED) ? grant_q : winner;
    selActive = aresetn && ((state_q == LOCKED) || found);
    canTake   = !bufValid_q || m_axis.ready;
    accept    = selActive && canTake && reqValid[selIdx];
    if (selActive && canTake) reqReady[selIdx] = 1'b1;
    // A last beat accepted in the grant cycle never leaves IDLE; the pointer still advances.
    if (selActive) begin
      if (accept && reqLast[selIdx]) begin
        state_d = IDLE;
        rrPtr_d = (int'(selIdx) == NUM_REQ - 1) ? '0 : selIdx + 1'b1;
      end else begin
        state_d = LOCKED;
        grant_d = selIdx;
      end
    end
  end

  assign selOneHot = NUM_REQ'(1) << selIdx;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rrPtr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rrPtr_q <= rrPtr_d;
    end
  end

  // Single output register: reload whenever it is empty or being drained, else hold.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bufValid_q <= 1'b0;
      bufLast_q  <= 1'b0;
      bufData_q  <= '0;
      bufKeep_q  <= '0;
      bufSize_q  <= '0;
      bufSrc_q   <= '0;
    end else if (canTake) begin
      bufValid_q <= accept;
      if (accept) begin
        bufLast_q <= reqLast[selIdx];
        bufData_q <= reqData[selIdx];
        bufKeep_q <= reqKeep[selIdx];
        bufSize_q <= reqSize[selIdx];
        bufSrc_q  <= selOneHot;
      end
    end
  end

  assign m_axis.valid             = bufValid_q;
  assign m_axis.user_valid        = bufValid_q;
  assign m_axis.data              = bufData_q;
  assign m_axis.keep              = bufKeep_q;
  assign m_axis.last              = bufLast_q;
  assign m_axis.user_size         = bufSize_q;
  assign m_axis.user_src_pf       = bufSrc_q[NUM_PHYS_FUNC-1:0];
  assign m_axis.user_src_cmac     = bufSrc_q[NUM_REQ-1:NUM_PHYS_FUNC];
  assign m_axis.user_dst_pf       = '0;
  assign m_axis.user_dst_cmac     = '0;
  assign m_axis.user_to_direction = 1'b0;

`ifdef INGRESS_ARBITER_STATS_EN
  logic [31:0] pktCount_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pktCount_q <= '0;
    end else if (bufValid_q && m_axis.ready && bufLast_q) begin
      pktCount_q <= pktCount_q + 32'd1;
    end
  end

  assign pkt_count = pktCount_q;
`endif

endmodule

// File: tb/tb_ingress_arbiter.sv
// Randomized and directed bench for ingress_arbiter (2 PF + 2 CMAC) against a
// packet-level round-robin reference model kept in the bench.
module tb_ingress_arbiter;
  localparam int NPF = 2, NCMAC = 2, NSRC = 4;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [15:0] size;
    int          gap;
  } beat_t;

  typedef struct {
    int          src;
    logic [63:0] data;
    int          cyc;
    logic [1:0]  pf;
    logic [1:0]  cmac;
    logic        uv;
    logic        dir;
    logic        last;
  } out_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic mReady = 1'b0;
  logic [NSRC-1:0] srcValid = '0;
  logic [NSRC-1:0] srcLast = '0;
  logic [NSRC-1:0] srcReady;
  logic [63:0] srcData [NSRC];
  logic [7:0]  srcKeep [NSRC];
  logic [15:0] srcSize [NSRC];
`ifdef INGRESS_ARBITER_STATS_EN
  logic [31:0] pktCount;
`endif

  beat_t       srcQ [NSRC][$];
  logic [63:0] expData [NSRC][$];
  out_t        outLog[$];
  int          waitCnt [NSRC];
  int          hsCount [NSRC];
  logic [NSRC-1:0] hsPending = '0;
  int cycle = 0, cmpCount = 0, failCount = 0, readyMode = 0;

  int          mOwner = -1, mPtr = 0, mBufSrc = 0;
  logic        mBufValid = 1'b0;
  beat_t       mBuf;
  logic [31:0] mPkt = '0;

  axi_stream_if #(.DATA_W(64), .SIZE_W(16)) pfIf [NPF] ();
  axi_stream_if #(.DATA_W(64), .SIZE_W(16)) cmacIf [NCMAC] ();
  axi_stream_vnp4_if #(.DATA_W(64), .SIZE_W(16), .NUM_PF(NPF), .NUM_CMAC(NCMAC)) mIf ();

  for (genvar g = 0; g < NPF; g++) begin : gPf
    assign pfIf[g].valid     = srcValid[g];
    assign pfIf[g].data      = srcData[g];
    assign pfIf[g].keep      = srcKeep[g];
    assign pfIf[g].last      = srcLast[g];
    assign pfIf[g].user_size = srcSize[g];
    assign srcReady[g]       = pfIf[g].ready;
  end
  for (genvar g = 0; g < NCMAC; g++) begin : gCmac
    assign cmacIf[g].valid     = srcValid[NPF+g];
    assign cmacIf[g].data      = srcData[NPF+g];
    assign cmacIf[g].keep      = srcKeep[NPF+g];
    assign cmacIf[g].last      = srcLast[NPF+g];
    assign cmacIf[g].user_size = srcSize[NPF+g];
    assign srcReady[NPF+g]     = cmacIf[g].ready;
  end
  assign mIf.ready = mReady;

  ingress_arbiter #(
    .NUM_PHYS_FUNC(NPF), .NUM_CMAC_PORT(NCMAC), .DATA_W(64), .SIZE_W(16)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis_pf(pfIf),
    .s_axis_cmac(cmacIf),
    .m_axis(mIf)
`ifdef INGRESS_ARBITER_STATS_EN
    , .pkt_count(pktCount)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic addBeat(input int s, input logic [63:0] d, input logic last, input int gap);
    beat_t b;
    b.data = d;
    b.keep = 8'($urandom);
    b.last = last;
    b.size = 16'($urandom_range(1, 1500));
    b.gap  = gap;
    srcQ[s].push_back(b);
    expData[s].push_back(d);
  endtask

  task automatic addPacket(input int s, input int pkt, input int len, input int maxGap);
    for (int i = 0; i < len; i++)
      addBeat(s, {8'(s), 8'(pkt), 8'(i), 40'($urandom)}, i == len - 1, $urandom_range(0, maxGap));
  endtask

  // Reference model: one packet owner at a time, picked round-robin from the
  // source after the last finished one, feeding a one-deep output slot.
  task automatic checkOutput();
    int sel;
    logic canTake, acc;
    out_t e;
    check("m_valid", 64'(mIf.valid), 64'(mBufValid));
    check("m_user_valid", 64'(mIf.user_valid), 64'(mBufValid));
    check("m_dst_dir_zero", 64'({mIf.user_dst_pf, mIf.user_dst_cmac, mIf.user_to_direction}), 64'(0));
    if (mBufValid) begin
      check("m_data", mIf.data, mBuf.data);
      check("m_keep", 64'(mIf.keep), 64'(mBuf.keep));
      check("m_last", 64'(mIf.last), 64'(mBuf.last));
      check("m_size", 64'(mIf.user_size), 64'(mBuf.size));
      check("m_src_pf", 64'(mIf.user_src_pf), (mBufSrc < NPF) ? 64'(1 << mBufSrc) : 64'(0));
      check("m_src_cmac", 64'(mIf.user_src_cmac), (mBufSrc >= NPF) ? 64'(1 << (mBufSrc - NPF)) : 64'(0));
    end
`ifdef INGRESS_ARBITER_STATS_EN
    check("pkt_count", 64'(pktCount), 64'(mPkt));
`endif
    canTake = !mBufValid || mReady;
    sel = mOwner;
    if (sel < 0)
      for (int k = 0; k < NSRC; k++)
        if (sel < 0 && srcValid[(mPtr + k) % NSRC]) sel = (mPtr + k) % NSRC;
    for (int s = 0; s < NSRC; s++)
      check($sformatf("s_ready_%0d", s), 64'(srcReady[s]), 64'(sel == s && canTake));

    for (int s = 0; s < NSRC; s++)
      if (srcValid[s] && srcReady[s]) begin
        hsPending[s] = 1'b1;
        hsCount[s]++;
      end
    if (mIf.valid && mReady) begin
      case ({mIf.user_src_pf, mIf.user_src_cmac})
        4'b0100: e.src = 0;
        4'b1000: e.src = 1;
        4'b0001: e.src = 2;
        4'b0010: e.src = 3;
        default: e.src = -1;
      endcase
      e.data = mIf.data;
      e.cyc  = cycle;
      e.pf   = mIf.user_src_pf;
      e.cmac = mIf.user_src_cmac;
      e.uv   = mIf.user_valid;
      e.dir  = mIf.user_to_direction;
      e.last = mIf.last;
      outLog.push_back(e);
    end

    if (mBufValid && mReady && mBuf.last) mPkt = mPkt + 32'd1;
    acc = (sel >= 0) && canTake && srcValid[sel];
    if (canTake) begin
      mBufValid = acc;
      if (acc) begin
        mBuf.data = srcData[sel];
        mBuf.keep = srcKeep[sel];
        mBuf.last = srcLast[sel];
        mBuf.size = srcSize[sel];
        mBufSrc   = sel;
      end
    end
    if (acc && srcLast[sel]) begin
      mOwner = -1;
      mPtr   = (sel + 1) % NSRC;
    end else if (sel >= 0) begin
      mOwner = sel;
    end
  endtask

  task automatic applyStimulus();
    beat_t b;
    @(negedge aclk);
    cycle++;
    for (int s = 0; s < NSRC; s++)
      if (hsPending[s]) begin
        void'(srcQ[s].pop_front());
        srcValid[s] = 1'b0;
        waitCnt[s]  = 0;
      end
    hsPending = '0;
    for (int s = 0; s < NSRC; s++)
      if (!srcValid[s] && srcQ[s].size() > 0) begin
        b = srcQ[s][0];
        if (waitCnt[s] >= b.gap) begin
          srcValid[s] = 1'b1;
          srcData[s]  = b.data;
          srcKeep[s]  = b.keep;
          srcLast[s]  = b.last;
          srcSize[s]  = b.size;
        end else begin
          waitCnt[s]++;
        end
      end
    case (readyMode)
      0:       mReady = 1'b1;
      1:       mReady = ($urandom_range(0, 3) != 0);
      default: mReady = (cycle % 3 == 0);
    endcase
    #1;
    checkOutput();
  endtask

  task automatic resetDut(input int cycles);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("rst_m_valid", 64'(mIf.valid), 64'(0));
    check("rst_user_valid", 64'(mIf.user_valid), 64'(0));
    check("rst_s_ready", 64'(srcReady), 64'(0));
`ifdef INGRESS_ARBITER_STATS_EN
    check("rst_pkt_count", 64'(pktCount), 64'(0));
`endif
    hsPending = '0;
    srcValid  = '0;
    srcLast   = '0;
    for (int s = 0; s < NSRC; s++) begin
      srcQ[s].delete();
      expData[s].delete();
      waitCnt[s] = 0;
    end
    mOwner = -1;
    mPtr = 0;
    mBufValid = 1'b0;
    mPkt = '0;
    repeat (cycles) @(negedge aclk);
    #1;
    check("rst_m_valid_hold", 64'(mIf.valid), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic runUntil(input int n, input int budget, input string name);
    int k = 0;
    while (outLog.size() < n && k < budget) begin
      applyStimulus();
      k++;
    end
    check(name, 64'(outLog.size()), 64'(n));
  endtask

  task automatic runIdle(input int n);
    repeat (n) applyStimulus();
  endtask

  function automatic bit busy();
    bit r = mBufValid || (srcValid != '0) || (hsPending != '0);
    for (int s = 0; s < NSRC; s++)
      if (srcQ[s].size() > 0) r = 1'b1;
    return r;
  endfunction

  initial begin
    int c0, total, k;
    for (int s = 0; s < NSRC; s++) begin
      srcData[s] = '0;
      srcKeep[s] = '0;
      srcSize[s] = '0;
      waitCnt[s] = 0;
      hsCount[s] = 0;
    end
    resetDut(3);

    // Four simultaneous 3-beat packets drain in index order, back to back.
    readyMode = 0;
    outLog.delete();
    for (int s = 0; s < NSRC; s++) addPacket(s, 1, 3, 0);
    c0 = cycle + 1;
    runUntil(12, 40, "029_beat_count");
    for (int i = 0; i < 12 && i < outLog.size(); i++) begin
      check($sformatf("029_src_%0d", i), 64'(outLog[i].src), 64'(i / 3));
      check($sformatf("029_beat_%0d", i), 64'(outLog[i].data[47:40]), 64'(i % 3));
      check($sformatf("029_cycle_%0d", i), 64'(outLog[i].cyc), 64'(c0 + 1 + i));
    end

    // Single-beat CMAC1 packet with a fixed pattern.
    outLog.delete();
    addBeat(3, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 0);
    c0 = cycle + 1;
    runUntil(1, 10, "030_count");
    if (outLog.size() > 0) begin
      check("030_data", outLog[0].data, 64'hA5A5_A5A5_A5A5_A5A5);
      check("030_src_cmac", 64'(outLog[0].cmac), 64'(2'b10));
      check("030_src_pf", 64'(outLog[0].pf), 64'(0));
      check("030_user_valid", 64'(outLog[0].uv), 64'(1));
      check("030_direction", 64'(outLog[0].dir), 64'(0));
      check("030_latency", 64'(outLog[0].cyc), 64'(c0 + 1));
    end

    // PF0 4-beat packet under a stalling consumer.
    readyMode = 2;
    outLog.delete();
    for (int i = 0; i < 4; i++) addBeat(0, 64'h3100_0000_0000_0000 | 64'(i), i == 3, 0);
    runUntil(4, 60, "031_count");
    runIdle(6);
    check("031_no_duplicates", 64'(outLog.size()), 64'(4));
    for (int i = 0; i < 4 && i < outLog.size(); i++) begin
      check($sformatf("031_data_%0d", i), outLog[i].data, 64'h3100_0000_0000_0000 | 64'(i));
      check($sformatf("031_last_%0d", i), 64'(outLog[i].last), 64'(i == 3));
    end

    // PF0 pauses mid-packet while CMAC0 waits; no preemption.
    readyMode = 0;
    outLog.delete();
    for (int i = 0; i < 4; i++) addBeat(0, 64'h3200_0000_0000_0000 | 64'(i), i == 3, (i == 2) ? 5 : 0);
    for (int i = 0; i < 2; i++) addBeat(2, 64'h3220_0000_0000_0000 | 64'(i), i == 1, (i == 0) ? 1 : 0);
    runUntil(6, 40, "032_count");
    for (int i = 0; i < 6 && i < outLog.size(); i++)
      check($sformatf("032_src_%0d", i), 64'(outLog[i].src), (i < 4) ? 64'(0) : 64'(2));
    if (outLog.size() >= 5)
      check("032_cmac_follows", 64'(outLog[4].cyc), 64'(outLog[3].cyc + 1));

    // Reset in the middle of a PF0 packet after the pointer was moved to CMAC1.
    outLog.delete();
    addBeat(2, 64'h3300_0000_0000_0000, 1'b1, 0);
    runUntil(1, 10, "033_pre_count");
    for (int i = 0; i < 5; i++) addBeat(0, 64'h3301_0000_0000_0000 | 64'(i), i == 4, 0);
    hsCount[0] = 0;
    k = 0;
    while (hsCount[0] < 2 && k < 50) begin
      applyStimulus();
      k++;
    end
    check("033_two_beats_in", 64'(hsCount[0]), 64'(2));
    resetDut(2);
    outLog.delete();
    addBeat(1, 64'h3310_0000_0000_0000, 1'b1, 0);
    addBeat(3, 64'h3330_0000_0000_0000, 1'b1, 0);
    runUntil(2, 20, "033_post_count");
    runIdle(5);
    check("033_no_remainder", 64'(outLog.size()), 64'(2));
    if (outLog.size() >= 2) begin
      check("033_first_pf1", 64'(outLog[0].src), 64'(1));
      check("033_then_cmac1", 64'(outLog[1].src), 64'(3));
    end

    // Random traffic with random backpressure and source gaps.
    readyMode = 1;
    outLog.delete();
    for (int s = 0; s < NSRC; s++) expData[s].delete();
    total = 0;
    for (int p = 0; p < 30; p++)
      for (int s = 0; s < NSRC; s++) begin
        k = $urandom_range(1, 5);
        addPacket(s, p, k, 2);
        total += k;
      end
    k = 0;
    while (busy() && k < 8000) begin
      applyStimulus();
      k++;
    end
    check("rand_drained", 64'(busy()), 64'(0));
    check("rand_total", 64'(outLog.size()), 64'(total));
    for (int i = 0; i < outLog.size(); i++) begin
      if (i > 0 && !outLog[i-1].last)
        check("rand_no_interleave", 64'(outLog[i].src), 64'(outLog[i-1].src));
      if (outLog[i].src < 0 || outLog[i].src >= NSRC)
        check("rand_src_decode", 64'(outLog[i].src), 64'(0));
      else if (expData[outLog[i].src].size() == 0)
        check("rand_extra_beat", 64'(0), 64'(1));
      else
        check("rand_src_order", outLog[i].data, expData[outLog[i].src].pop_front());
    end
    for (int s = 0; s < NSRC; s++)
      check($sformatf("rand_left_%0d", s), 64'(expData[s].size()), 64'(0));

`ifdef INGRESS_ARBITER_STATS_EN
    resetDut(2);
    readyMode = 0;
    outLog.delete();
    for (int s = 0; s < 3; s++) addBeat(s, 64'h3400_0000_0000_0000 | 64'(s), 1'b1, 0);
    runUntil(3, 20, "034_count");
    runIdle(2);
    check("034_pkt_count_3", 64'(pktCount), 64'(3));
    @(negedge aclk);
    force dut.pktCount_q = 32'hFFFF_FFFF;
    #1;
    release dut.pktCount_q;
    mPkt = 32'hFFFF_FFFF;
    outLog.delete();
    addBeat(0, 64'h3410_0000_0000_0000, 1'b1, 0);
    runUntil(1, 10, "034_wrap_count");
    runIdle(2);
    check("034_pkt_count_wrap", 64'(pktCount), 64'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ingress_arbiter.md
INGRESS_ARBITER -- requirements
Module: ingress_arbiter

Interface
REQ-001 SHALL have parameter NUM_PHYS_FUNC, default 1, number of PF source ports (1..4).
REQ-002 SHALL have parameter NUM_CMAC_PORT, default 1, number of CMAC source ports (1..10).
REQ-003 SHALL have port aclk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_pf  axi_stream_if.slave  array[NUM_PHYS_FUNC]  per-PF ingress stream.
REQ-006 SHALL have port s_axis_cmac  axi_stream_if.slave  array[NUM_CMAC_PORT]  per-CMAC ingress stream.
REQ-007 SHALL have port m_axis  axi_stream_vnp4_if.master  1  merged stream toward the VNP4 pipeline.
REQ-008 SHALL have port pkt_count  output  32  packets forwarded; present only under REQ-027.

Function
REQ-009 SHALL index requestors in this order: PF0..PF(NUM_PHYS_FUNC-1), then CMAC0..CMAC(NUM_CMAC_PORT-1).
REQ-010 SHALL run a two-state FSM: IDLE (no grant) and LOCKED (one requestor granted).
REQ-011 IDLE -> LOCKED SHALL occur on any clock where at least one s_axis valid is high; grant = first valid requestor at or after rr_ptr, searching with wrap-around.
REQ-012 The winner's first beat SHALL be accepted in the grant cycle if the output register can take it.
REQ-013 LOCKED -> IDLE SHALL occur on the clock where the granted source's beat with last=1 is accepted.
REQ-014 On that same clock, rr_ptr SHALL be set to granted index+1, wrapping to 0 past the final index.
REQ-015 Grant SHALL stay fixed for the whole packet; no interleaving of beats from different sources.
REQ-016 s_axis ready to the granted source SHALL be high when (!buf_valid || m_axis.ready); ready to every other source SHALL be 0.
REQ-017 The output SHALL be a single register stage: accepted beat appears on m_axis one cycle later, full throughput of 1 beat/cycle under continuous m_axis.ready.
REQ-018 m_axis.valid and m_axis.user_valid SHALL both equal buf_valid.
REQ-019 buf_valid SHALL hold with data stable while m_axis.ready=0.
REQ-020 m_axis data, keep, last and user_size SHALL be copied from the accepted beat.
REQ-021 For a PF source i, user_src_pf SHALL be one-hot bit i and user_src_cmac SHALL be 0.
REQ-022 For a CMAC source j, user_src_cmac SHALL be one-hot bit j and user_src_pf SHALL be 0.
REQ-023 user_dst_pf, user_dst_cmac and user_to_direction SHALL be driven 0; the pipeline assigns them.
REQ-024 When the granted source drops valid mid-packet, the arbiter SHALL stay LOCKED and wait; it SHALL have no timeout.
REQ-025 A single-beat packet (last on first beat) SHALL enter and leave LOCKED, and advance rr_ptr, on the acceptance clock.

Reset
REQ-026 While aresetn=0: FSM=IDLE, rr_ptr=0, buf_valid=0, m_axis.valid=0, m_axis.user_valid=0, all s_axis ready=0, pkt_count=0. Reset mid-packet SHALL drop the partial packet, with no output of the remainder after release.

Configuration
REQ-027 Macro INGRESS_ARBITER_STATS_EN defined: pkt_count port SHALL exist and increment by 1 on each m_axis handshake with last=1, wrapping 0xFFFFFFFF->0.
REQ-028 Macro INGRESS_ARBITER_STATS_EN undefined: pkt_count port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-029 NUM_PHYS_FUNC=2, NUM_CMAC_PORT=2; PF0, PF1, CMAC0 and CMAC1 each send a 3-beat packet at once, m_axis.ready=1 -> output order PF0, PF1, CMAC0, CMAC1 with no interleave; 12 beats in 12 consecutive cycles after the first.
REQ-030 CMAC1 sends a 1-beat packet with data=0xA5.. -> m_axis one cycle later with user_src_cmac=0b10, user_src_pf=0, user_valid=1, user_to_direction=0.
REQ-031 PF0 sends a 4-beat packet while m_axis.ready toggles 1,0,0,1,... -> every beat delivered exactly once in order, output stable while ready=0.
REQ-032 PF0 valid gap of 5 cycles after beat 2 while CMAC0 is valid -> no CMAC0 beat until PF0 last accepted, then CMAC0 granted.
REQ-033 aresetn asserted after beat 2 of a 5-beat packet -> m_axis.valid=0 immediately; after release, the next packet from PF1 is granted first (rr_ptr=0 scan).
REQ-034 With INGRESS_ARBITER_STATS_EN, 3 packets forwarded -> pkt_count=3; counter preloaded to 0xFFFFFFFF, 1 packet -> 0.
